// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_CNT    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_CNT    = (PTR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_w_ptr;
  logic [PTR_WIDTH:0]    r_r_ptr;
  logic [PTR_WIDTH:0]    r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] w_head;

  assign full         = (r_count == DEPTH_CNT);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Acceptance is judged on the flags as they stand before the edge
  assign w_wr_accept = w_en && !full;
  assign w_rd_accept = r_en && !empty;
  assign w_head      = r_mem[r_r_ptr[PTR_WIDTH-1:0]];

  // Storage carries no reset; only written entries are ever observable
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_w_ptr[PTR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_accept) begin
        r_w_ptr <= r_w_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_r_ptr <= r_r_ptr + 1'b1;
      end
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_data_out <= w_head;
      end
    end
  end

  // A new error on the same edge as clr_err takes priority over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (r_en && empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // In FWFT mode the head is presented directly; zero while empty keeps reset output clean
  always_comb begin
    data_out = r_data_out;
    rd_valid = r_rd_valid;
    if (FWFT != 0) begin
      data_out = empty ? '0 : w_head;
      rd_valid = !empty;
    end
  end

endmodule
